// File: rtl/jedro_1_data_bus_responder.sv
// -----------------------------------------------------------------------------
// jedro_1_data_bus_responder
//
// Slave-side responder for the jedro_1 core data-memory bus. Models a
// word-addressed RAM with byte-enable writes and a fixed number of wait
// states. It also provides a "tohost" mailbox word that latches a pass/fail
// code written by a directed test program.
//
// Ports:
//   clk_i        in   1           clock, rising edge
//   rst_i        in   1           asynchronous, active-high reset
//   req_i        in   1           request, held by the master until ack_o
//   we_i         in   4           byte write enables, 0 = read
//   addr_i       in   ADDR_WIDTH  byte address, bits [1:0] ignored
//   wdata_i      in   DATA_WIDTH  lane-aligned write data
//   ack_o        out  1           one-cycle completion pulse
//   rdata_o      out  DATA_WIDTH  read data, valid with ack_o, 0 otherwise
//   err_o        out  1           pulses with ack_o for an unmapped address
//   test_done_o  out  1           sticky, set by any mailbox write
//   test_code_o  out  DATA_WIDTH  last value merged into the mailbox
//
// Timing: a request sampled in IDLE at edge N is acted on at the edge that
// leaves RESP (N+1+WAIT_CYCLES); all responses are registered, so ack_o is
// high in the cycle after that edge.
// -----------------------------------------------------------------------------
module jedro_1_data_bus_responder #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 256,
  parameter int unsigned           WAIT_CYCLES = 0,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  test_done_o,
  output logic [DATA_WIDTH-1:0] test_code_o
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Counter preload: the WAIT state is visited WAIT_CYCLES times, so the
  // counter starts one below and RESP follows the cycle where it reads 0.
  localparam logic [2:0]            WAIT_LOAD     = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
  localparam logic [IDX_W-1:0]      RAM_WORDS     = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0]      TOHOST_IDX    = TOHOST_ADDR[ADDR_WIDTH-1:2];
  localparam logic [DATA_WIDTH-1:0] UNMAPPED_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      addr_q, addr_d;    // captured word index
  logic [3:0]            we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] code_q, code_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [3:0]            mem_we;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  ram_hit;
  logic                  mbox_hit;

  // Byte-offset bits of the address carry no information for a word bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  // Decode always works on the captured address, never on the live bus.
  assign ram_hit  = (addr_q < RAM_WORDS);
  assign mbox_hit = (addr_q == TOHOST_IDX);
  assign mem_idx  = addr_q[MEM_AW-1:0];

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [3:0]            be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    done_d  = done_q;
    code_d  = code_q;
    mem_we  = 4'b0000;

    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d  = addr_i[ADDR_WIDTH-1:2];
          we_d    = we_i;
          wdata_d = wdata_i;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
        if (ram_hit) begin
          if (we_q != 4'b0000) mem_we  = we_q;
          else                 rdata_d = mem[mem_idx];
        end else if (mbox_hit) begin
          if (we_q != 4'b0000) begin
            code_d = merge_bytes(code_q, wdata_q, we_q);
            done_d = 1'b1;
          end else begin
            rdata_d = code_q;
          end
        end else begin
          // Unmapped: flag the error and leave all state untouched.
          err_d = 1'b1;
          if (we_q == 4'b0000) rdata_d = UNMAPPED_DATA;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  // NOTE: the RAM array is deliberately not reset so it can map onto plain
  // memory; an abort by reset is safe because mem_we derives from state_q,
  // which the asynchronous reset forces out of RESP immediately.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we[b]) mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign test_done_o = done_q;
  assign test_code_o = code_q;

endmodule

// File: tb/tb_jedro_1_data_bus_responder.sv
// -----------------------------------------------------------------------------
// Bench for jedro_1_data_bus_responder. Instance 0 runs with no wait states,
// instance 1 with three. Expected values come from a word-array model of the
// RAM plus mailbox, updated per transaction from the bus rules.
// -----------------------------------------------------------------------------
module tb_jedro_1_data_bus_responder;

  localparam int unsigned TOHOST_WORD = 32'h0000_1000 / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        req   [2];
  logic [3:0]  we_s  [2];
  logic [31:0] addr_s[2];
  logic [31:0] wdat_s[2];
  logic        ack_s [2];
  logic [31:0] rdat_s[2];
  logic        err_s [2];
  logic        done_s[2];
  logic [31:0] code_s[2];

  jedro_1_data_bus_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we_s[0]),
    .addr_i(addr_s[0]), .wdata_i(wdat_s[0]), .ack_o(ack_s[0]),
    .rdata_o(rdat_s[0]), .err_o(err_s[0]), .test_done_o(done_s[0]),
    .test_code_o(code_s[0])
  );

  jedro_1_data_bus_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we_s[1]),
    .addr_i(addr_s[1]), .wdata_i(wdat_s[1]), .ack_o(ack_s[1]),
    .rdata_o(rdat_s[1]), .err_o(err_s[1]), .test_done_o(done_s[1]),
    .test_code_o(code_s[1])
  );

  // Reference model state, one copy per instance.
  logic [31:0] m_ram [2][256];
  logic        m_done[2];
  logic [31:0] m_code[2];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int wait_of(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Applies one bus access to the model and returns the response the bus
  // should give: reads see old contents, writes merge through byte enables.
  task automatic model(input int s, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
    int unsigned idx;
    idx = a >> 2;
    rd  = '0;
    er  = 1'b0;
    if (idx < 256) begin
      if (w != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (w[b]) m_ram[s][idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        rd = m_ram[s][idx];
      end
    end else if (idx == TOHOST_WORD) begin
      if (w != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (w[b]) m_code[s][8*b +: 8] = d[8*b +: 8];
        m_done[s] = 1'b1;
      end else begin
        rd = m_code[s];
      end
    end else begin
      er = 1'b1;
      if (w == 4'b0000) rd = 32'hDEAD_BEEF;
    end
  endtask

  // One bus transaction as a master that holds req until it sees ack.
  // With scramble set, addr/wdata are changed every cycle after capture.
  task automatic txn(input int s, input logic [31:0] a, input logic [3:0] w,
                     input logic [31:0] d, input bit scramble,
                     output logic [31:0] rd, output logic er);
    int          lat;
    bit          got;
    logic [31:0] e_rd;
    logic        e_er;
    @(negedge clk);
    req[s] = 1'b1; addr_s[s] = a; we_s[s] = w; wdat_s[s] = d;
    @(posedge clk);
    lat = 0; got = 1'b0; rd = '0; er = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (ack_s[s]) got = 1'b1;
      else begin
        lat++;
        if (scramble) begin
          addr_s[s] = $urandom;
          wdat_s[s] = $urandom;
        end
      end
    end
    req[s] = 1'b0;
    check($sformatf("ack_seen_i%0d_a%h", s, a), 32'(got), 32'd1);
    if (got) begin
      model(s, a, w, d, e_rd, e_er);
      check($sformatf("latency_i%0d", s), 32'(lat), 32'(1 + wait_of(s)));
      check($sformatf("err_i%0d_a%h", s, a), 32'(err_s[s]), 32'(e_er));
      if (w == 4'b0000) check($sformatf("rdata_i%0d_a%h", s, a), rdat_s[s], e_rd);
      check($sformatf("done_i%0d", s), 32'(done_s[s]), 32'(m_done[s]));
      check($sformatf("code_i%0d", s), code_s[s], m_code[s]);
      rd = rdat_s[s];
      er = err_s[s];
      @(negedge clk);
      check($sformatf("ack_pulse_i%0d", s), 32'(ack_s[s]), 32'd0);
      check($sformatf("rdata_idle_i%0d", s), rdat_s[s], 32'd0);
    end
  endtask

  task automatic check_outputs_zero(input int s, input string tag);
    check({tag, "_ack"},  32'(ack_s[s]),  32'd0);
    check({tag, "_err"},  32'(err_s[s]),  32'd0);
    check({tag, "_rdat"}, rdat_s[s],      32'd0);
    check({tag, "_done"}, 32'(done_s[s]), 32'd0);
    check({tag, "_code"}, code_s[s],      32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [3:0]  w;
    int          kind;
    bit          ack_during_rst;

    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; req[s] = 1'b0; we_s[s] = '0; addr_s[s] = '0; wdat_s[s] = '0;
      m_done[s] = 1'b0; m_code[s] = '0;
    end

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero(0, "rst_i0");
    check_outputs_zero(1, "rst_i1");
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Word round trip, no wait states.
    txn(0, 32'h10, 4'hF, 32'hCAFE_F00D, 1'b0, rd, er);
    txn(0, 32'h10, 4'h0, 32'h0, 1'b0, rd, er);
    check("roundtrip_data", rd, 32'hCAFE_F00D);
    check("roundtrip_err", 32'(er), 32'd0);

    // Byte lanes.
    txn(0, 32'h20, 4'hF, 32'h1122_3344, 1'b0, rd, er);
    txn(0, 32'h20, 4'b0101, 32'hAABB_CCDD, 1'b0, rd, er);
    txn(0, 32'h22, 4'h0, 32'h0, 1'b0, rd, er);
    check("byte_lanes", rd, 32'h11BB_33DD);

    // Mailbox.
    txn(0, 32'h0000_1000, 4'hF, 32'h1, 1'b0, rd, er);
    check("mbox_done_1", 32'(done_s[0]), 32'd1);
    check("mbox_code_1", code_s[0], 32'd1);
    txn(0, 32'h0000_1000, 4'hF, 32'h0, 1'b0, rd, er);
    check("mbox_done_sticky", 32'(done_s[0]), 32'd1);
    check("mbox_code_0", code_s[0], 32'd0);
    txn(0, 32'h0000_1000, 4'h0, 32'h0, 1'b0, rd, er);
    check("mbox_read", rd, 32'd0);

    // Fill words 0..15 so every later random read hits known contents.
    for (int i = 0; i < 16; i++) begin
      if (i != 4 && i != 8) txn(0, 32'(i * 4), 4'hF, $urandom, 1'b0, rd, er);
    end

    // Unmapped access; 0x8000 aliases word 0 if the upper index bits were dropped.
    txn(0, 32'h8000, 4'hF, 32'h5, 1'b0, rd, er);
    check("unmapped_wr_err", 32'(er), 32'd1);
    txn(0, 32'h10, 4'h0, 32'h0, 1'b0, rd, er);
    check("unmapped_ram_kept", rd, 32'hCAFE_F00D);
    txn(0, 32'h0, 4'h0, 32'h0, 1'b0, rd, er);
    txn(0, 32'h8000, 4'h0, 32'h0, 1'b0, rd, er);
    check("unmapped_rd_data", rd, 32'hDEAD_BEEF);
    check("unmapped_rd_err", 32'(er), 32'd1);

    // Randomized mix of RAM, mailbox and unmapped accesses.
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 6)      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else if (kind == 7) a = 32'h0000_1000 + 32'($urandom_range(0, 3));
      else                a = 32'h0001_0000 | ($urandom & 32'h0000_FFFF);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      txn(0, a, w, $urandom, 1'b1, rd, er);
    end

    // Wait states: mailbox write, then a word round trip with a scrambled bus.
    txn(1, 32'h0000_1000, 4'hF, 32'h77, 1'b0, rd, er);
    txn(1, 32'h30, 4'hF, 32'h1357_9BDF, 1'b0, rd, er);
    txn(1, 32'h30, 4'h0, 32'h0, 1'b1, rd, er);
    check("wait_scrambled_read", rd, 32'h1357_9BDF);

    // Reset in the second WAIT cycle of a write aborts it.
    @(negedge clk);
    req[1] = 1'b1; addr_s[1] = 32'h30; we_s[1] = 4'hF; wdat_s[1] = 32'h0BAD_0BAD;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    req[1] = 1'b0;
    #1;
    check_outputs_zero(1, "midop_rst_a");
    ack_during_rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack_s[1]) ack_during_rst = 1'b1;
    end
    check("midop_no_ack", 32'(ack_during_rst), 32'd0);
    check_outputs_zero(1, "midop_rst_b");
    rst[1] = 1'b0;
    m_done[1] = 1'b0;
    m_code[1] = '0;
    txn(1, 32'h30, 4'h0, 32'h0, 1'b0, rd, er);
    check("midop_old_value", rd, 32'h1357_9BDF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jedro_1_data_bus_responder.md
Name: jedro_1_data_bus_responder

Overview:
Slave-side responder for the jedro_1 core data-memory bus. It answers load/store requests from the core's data port. It models a word-addressed RAM with byte-enable writes and a configurable number of wait states. It also provides a "tohost" mailbox that latches a test pass/fail code, so directed-program benches can end on a core store instead of polling the register file.

Parameters:
DATA_WIDTH, 32, data bus width; fixed at 32 (4 byte lanes).
ADDR_WIDTH, 32, byte-address width.
DEPTH, 256, number of 32-bit words of backing RAM; must be a power of 2.
WAIT_CYCLES, 0, wait states inserted before ack; legal range 0..7.
TOHOST_ADDR, 32'h0000_1000, byte address of the mailbox word; must lie outside the RAM range.

Ports:
clk_i  in  1  clock; all logic is rising-edge.
rst_i  in  1  reset, asynchronous, active-high.
req_i  in  1  request from the core; held until ack_o.
we_i  in  4  byte write enables; 0 means read.
addr_i  in  ADDR_WIDTH  byte address; bits [1:0] are ignored.
wdata_i  in  DATA_WIDTH  write data, lane-aligned.
ack_o  out  1  one-cycle completion pulse.
rdata_o  out  DATA_WIDTH  read data, valid only when ack_o=1.
err_o  out  1  pulses with ack_o for an unmapped address.
test_done_o  out  1  sticky flag, set by a mailbox write.
test_code_o  out  DATA_WIDTH  value written to the mailbox.

Behaviour:
- Reset (asynchronous):
  - Outputs: ack_o=0, err_o=0, rdata_o=0, test_done_o=0, test_code_o=0.
  - FSM goes to IDLE and the wait counter clears.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when req_i=1, capture addr_i, we_i and wdata_i.
    - If WAIT_CYCLES=0, go to RESP.
    - Otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
  - WAIT: decrement the counter each cycle; go to RESP when the counter is 0.
  - RESP: drive ack_o=1 for exactly one cycle, then return to IDLE.
- Latency: request sampled at edge N -> ack_o high in the cycle after edge N+1+WAIT_CYCLES.
  - Back-to-back requests cost 2+WAIT_CYCLES cycles each.
  - A req_i still high in RESP is not accepted; it is sampled in IDLE on the next cycle.
- The captured request is authoritative. Changes to req_i, addr_i or wdata_i after capture are ignored, and a captured transaction always completes.
- Address decode, word index = addr[ADDR_WIDTH-1:2]:
  - RAM hit: index < DEPTH.
  - Mailbox hit: addr[ADDR_WIDTH-1:2] == TOHOST_ADDR[ADDR_WIDTH-1:2].
  - Anything else is unmapped.
- Writes (we≠0) are committed on the RESP cycle.
  - RAM: update only the lanes whose we bit is 1; other bytes are untouched.
  - Mailbox: test_code_o takes wdata merged through the byte enables over its current value, and test_done_o is set.
  - test_done_o stays 1 until reset; later mailbox writes update test_code_o.
- Reads (we=0): rdata_o is driven in RESP.
  - RAM: the stored word.
  - Mailbox: the current test_code_o.
  - Unmapped: 32'hDEAD_BEEF.
  - rdata_o returns to 0 when ack_o is 0.
- Unmapped access: err_o=1 together with ack_o, and no state changes.
- Reset during WAIT or RESP aborts the transaction:
  - no write is committed and no ack is issued;
  - the master must reissue the request after reset.

Test Plan:
- Word round trip, WAIT_CYCLES=0: write 0xCAFE_F00D to 0x10 with we=4'hF, then read 0x10 -> rdata_o=0xCAFE_F00D; each ack_o comes 2 cycles after req sampling, err_o=0.
- Byte lanes: preload 0x1122_3344 at 0x20, write 0xAABB_CCDD with we=4'b0101, then read -> 0x11BB_33DD.
- Wait states, WAIT_CYCLES=3: read -> ack_o exactly 5 cycles after req sampling.
  - addr_i toggled during WAIT does not change the returned word.
- Mailbox: store 0x1 to TOHOST_ADDR -> test_done_o=1, test_code_o=1.
  - A second store of 0x0 -> test_code_o=0, test_done_o stays 1.
  - A mailbox read returns 0.
- Unmapped: write 0x5 to 0x8000 -> err_o=1 with ack_o; RAM is unchanged; a read of the same address returns 0xDEAD_BEEF with err_o=1.
- Reset mid-op, WAIT_CYCLES=3: assert rst_i in the second WAIT cycle of a write to 0x30 -> no ack_o; a later read of 0x30 returns the old value; all outputs are 0 while rst_i=1.
